task_manager_core: RTL and testbench
====================================

Name: task_manager_core

Overview:
- Top-level mission sequencer for the robot drive path.
- On a one-cycle start pulse, runs a timed sequence: drive forward for a fixed number of seconds, pause, then finish.
- Timing comes from a one-cycle-per-second enable strobe, produced by a companion clock-divider sub-module.
- Output enable_forward gates the downstream PWM/motor block; state is exported for debug LEDs.

Parameters:
- FORWARD_TICKS, 5, number of oneHz_enable strobes spent in FORWARD.
- PAUSE_TICKS, 2, number of oneHz_enable strobes spent in PAUSE.
- DIVISION_PERIOD, 100, clocks per strobe; sub-module parameter only, 100 for simulation, 65_000_000 for the board.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  synchronous start request, sampled each clock; one-cycle pulse expected.
- oneHz_enable  input  1  one-clock-wide strobe, once per second.
- enable_forward  output  1  high while driving forward.
- state  output  2  current FSM state encoding.

Behaviour:
- State encoding: IDLE=2'd0, FORWARD=2'd1, PAUSE=2'd2, DONE=2'd3. The state output is the state register itself (registered, no combinational decode).
- Reset (reset==0, asynchronous):
  - state=IDLE, tick counter=0, enable_forward=0.
  - Takes effect immediately, including mid-sequence.
  - Release is synchronous to clk.
- IDLE:
  - start==1 at a rising edge -> FORWARD on that edge, counter cleared.
  - start==0 -> remain in IDLE.
- FORWARD:
  - enable_forward=1, as a Moore output of the registered state, so it asserts on the same edge state becomes FORWARD.
  - Each cycle with oneHz_enable==1 increments the counter.
  - On the edge where a strobe arrives with counter==FORWARD_TICKS-1 -> PAUSE, counter cleared.
  - The first "second" may be partial; strobe phase is not realigned.
- PAUSE:
  - enable_forward=0.
  - Counts strobes identically; at the PAUSE_TICKS-th strobe -> DONE, counter cleared.
- DONE:
  - enable_forward=0; holds indefinitely.
  - start==1 -> FORWARD (restart), counter cleared.
- start while in FORWARD or PAUSE: ignored, with no restart and no counter clear.
- start and oneHz_enable in the same cycle in IDLE: go to FORWARD; that strobe is not counted.
- Counter width: clog2(max(FORWARD_TICKS, PAUSE_TICKS)+1) bits; never wraps because it clears on every transition.
- Tick parameters of 0 are illegal. Assert them at elaboration (minimum value 1).

Decomposition:
- Shared package task_pkg:
  - state typedef/localparams IDLE/FORWARD/PAUSE/DONE (2-bit);
  - default tick counts;
  - DIVISION_PERIOD constants for sim and board.
- Sub-module pulse_divider:
  - ports clk, reset (async active-low), clk_divided output; parameter DIVISION_PERIOD.
  - Counter runs 0..DIVISION_PERIOD-1 and wraps.
  - clk_divided=1 for exactly one clock when counter==DIVISION_PERIOD-1, registered.
  - Reset clears counter and output. First pulse arrives DIVISION_PERIOD clocks after reset release.
- The system top instantiates pulse_divider, feeding its output to oneHz_enable. task_manager_core itself takes the strobe as an input so the strobe can be driven directly in tests.

Test Plan:
- Reset held low 50 clocks, then released with no start -> state=0, enable_forward=0 throughout; pulse_divider (period 100) first pulses 100 clocks after release, then every 100 clocks, each exactly 1 clock wide.
- Reset released, start pulsed 1 clock, pulse_divider driving oneHz_enable (period 100) -> state=1 and enable_forward=1 from the next edge; state=2 at the 5th strobe; state=3 at the 7th strobe; enable_forward=0 from the 5th strobe onward; state=3 still after 5000 clocks.
- In FORWARD after 2 strobes, pulse start -> no effect; the transition to PAUSE still happens at the 5th strobe after entry.
- In DONE, pulse start -> back to FORWARD with counter=0; a full 5+2 sequence repeats.
- Reset asserted mid-FORWARD, between clock edges -> state=0 and enable_forward=0 immediately, without waiting for a clock edge; after release, IDLE until a new start.
- Directly driven strobe: start and oneHz_enable high in the same cycle -> FORWARD; 5 further strobes are required to reach PAUSE.

Source files
------------

// File: rtl/task_pkg.sv
// task_pkg: shared state encoding and timing constants for the mission sequencer
package task_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    PAUSE   = 2'd2,
    DONE    = 2'd3
  } state_t;
  localparam int FORWARD_TICKS_DEF = 5;
  localparam int PAUSE_TICKS_DEF = 2;
  localparam int DIV_PERIOD_SIM = 100;
  localparam int DIV_PERIOD_BOARD = 65_000_000;
endpackage

// File: rtl/pulse_divider.sv
// pulse_divider: one-clock strobe every DIVISION_PERIOD clocks
module pulse_divider
  import task_pkg::*;
#(
  parameter int DIVISION_PERIOD = DIV_PERIOD_SIM
) (
  input  logic clk,
  input  logic reset,
  output logic clk_divided
);
  localparam int W = DIVISION_PERIOD > 1 ? $clog2(DIVISION_PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(DIVISION_PERIOD - 1);
  if (DIVISION_PERIOD < 1) begin : g_bad_period
    $error("DIVISION_PERIOD must be at least 1");
  end
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      clk_divided <= 1'b0;
    end else begin
      clk_divided <= cnt == LAST;
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/task_manager_core.sv
// task_manager_core: timed forward/pause/done mission sequencer paced by a 1 Hz strobe
module task_manager_core
  import task_pkg::*;
#(
  parameter int FORWARD_TICKS = FORWARD_TICKS_DEF,
  parameter int PAUSE_TICKS = PAUSE_TICKS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       oneHz_enable,
  output logic       enable_forward,
  output logic [1:0] state
);
  localparam int MAX_TICKS = FORWARD_TICKS > PAUSE_TICKS ? FORWARD_TICKS : PAUSE_TICKS;
  localparam int CW = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] F_LAST = CW'(FORWARD_TICKS - 1);
  localparam logic [CW-1:0] P_LAST = CW'(PAUSE_TICKS - 1);
  if (FORWARD_TICKS < 1 || PAUSE_TICKS < 1) begin : g_bad_ticks
    $error("tick parameters must be at least 1");
  end
  state_t state_r, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic counting, last;
  // start restarts only from IDLE/DONE; strobes count only in FORWARD/PAUSE
  always_comb begin
    counting = (state_r == FORWARD) || (state_r == PAUSE);
    last = (state_r == FORWARD) ? cnt == F_LAST : cnt == P_LAST;
    state_n = state_r;
    cnt_n = cnt;
    if (!counting && start) begin
      state_n = FORWARD;
      cnt_n = '0;
    end else if (counting && oneHz_enable) begin
      state_n = last ? ((state_r == FORWARD) ? PAUSE : DONE) : state_r;
      cnt_n = last ? '0 : cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt <= '0;
    end else begin
      state_r <= state_n;
      cnt <= cnt_n;
    end
  end
  assign state = state_r;
  assign enable_forward = state_r == FORWARD;
endmodule

// File: tb/tb_task_manager_core.sv
// tb_task_manager_core: vector table, directed corner cases and random stimulus vs a strobe-count model
module tb_task_manager_core;
  localparam int F = 5;
  localparam int P = 2;
  localparam int DIV = 100;
  typedef struct {
    bit s;
    bit t;
    bit [1:0] st;
    bit en;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic tb_strobe = 1'b0;
  logic sel_div = 1'b0;
  logic div_out, one_hz, enable_forward;
  logic [1:0] state;
  int total = 0;
  int bad = 0;
  int ph = 0;
  int m_seen = 0;
  bit m_started = 1'b0;
  vec_t vecs[22];

  assign one_hz = sel_div ? div_out : tb_strobe;
  always #5 clk = ~clk;

  pulse_divider #(.DIVISION_PERIOD(DIV)) u_div (
    .clk(clk),
    .reset(reset),
    .clk_divided(div_out)
  );

  task_manager_core #(.FORWARD_TICKS(F), .PAUSE_TICKS(P)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .oneHz_enable(one_hz),
    .enable_forward(enable_forward),
    .state(state)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Sequence position is just the number of strobes seen since the last start.
  function automatic int m_state();
    if (!m_started) return 0;
    if (m_seen < F) return 1;
    if (m_seen < F + P) return 2;
    return 3;
  endfunction

  task automatic cyc(input bit s, input bit t);
    bit eff;
    int cur;
    start = s;
    tb_strobe = t;
    eff = sel_div ? (ph > 0 && ph % DIV == 0) : t;
    if (!reset) begin
      m_started = 1'b0;
      m_seen = 0;
      ph = 0;
    end else begin
      cur = m_state();
      if ((cur == 0 || cur == 3) && s) begin
        m_started = 1'b1;
        m_seen = 0;
      end else if ((cur == 1 || cur == 2) && eff) begin
        m_seen++;
      end
      ph++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("state", int'(state), m_state());
    chk("enable_forward", int'(enable_forward), int'(m_state() == 1));
    chk("divider", int'(div_out), int'(ph > 0 && ph % DIV == 0));
  endtask

  initial begin
    vecs = '{
      '{1'b0, 1'b1, 2'd0, 1'b0}, '{1'b1, 1'b1, 2'd1, 1'b1}, '{1'b0, 1'b1, 2'd1, 1'b1},
      '{1'b0, 1'b0, 2'd1, 1'b1}, '{1'b0, 1'b1, 2'd1, 1'b1}, '{1'b1, 1'b0, 2'd1, 1'b1},
      '{1'b0, 1'b1, 2'd1, 1'b1}, '{1'b1, 1'b1, 2'd1, 1'b1}, '{1'b0, 1'b1, 2'd2, 1'b0},
      '{1'b1, 1'b0, 2'd2, 1'b0}, '{1'b0, 1'b1, 2'd2, 1'b0}, '{1'b1, 1'b1, 2'd3, 1'b0},
      '{1'b0, 1'b1, 2'd3, 1'b0}, '{1'b1, 1'b0, 2'd1, 1'b1}, '{1'b0, 1'b1, 2'd1, 1'b1},
      '{1'b0, 1'b1, 2'd1, 1'b1}, '{1'b0, 1'b1, 2'd1, 1'b1}, '{1'b0, 1'b1, 2'd1, 1'b1},
      '{1'b0, 1'b1, 2'd2, 1'b0}, '{1'b0, 1'b1, 2'd2, 1'b0}, '{1'b0, 1'b0, 2'd2, 1'b0},
      '{1'b0, 1'b1, 2'd3, 1'b0}
    };
    sel_div = 1'b1;
    repeat (50) cyc(1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (350) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("seq_enter_forward", int'(state), 1);
    for (int i = 0; i < 900; i++) cyc(i == 200, 1'b0);
    chk("seq_done", int'(state), 3);
    repeat (5000) cyc(1'b0, 1'b0);
    chk("done_hold", int'(state), 3);
    cyc(1'b1, 1'b0);
    chk("restart", int'(state), 1);
    repeat (800) cyc(1'b0, 1'b0);
    chk("second_done", int'(state), 3);

    sel_div = 1'b0;
    reset = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      cyc(vecs[i].s, vecs[i].t);
      chk($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].st));
      chk($sformatf("vec%0d_en", i), int'(enable_forward), int'(vecs[i].en));
    end

    reset = 1'b0;
    cyc(1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("pre_async_state", int'(state), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_en", int'(enable_forward), 0);
    repeat (3) cyc(1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'($urandom_range(0, 1)));
    chk("idle_after_reset", int'(state), 0);

    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 299) != 0;
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
    end
    reset = 1'b1;
    repeat (2) cyc(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
